// File: rtl/sram_controller_if.sv
// Request/response bundle between cache_controller (master) and sram_controller (slave).
interface sram_controller_if;
    logic        read_en;
    logic        write_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [63:0] read_data;
    logic        ready;

    modport master (
        output read_en, write_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  read_en, write_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// Sequences one 64-bit line read or 32-bit word write onto a 16-bit asynchronous SRAM.
// Optional SRAM_PERF_CNT_EN adds saturating read_count/write_count completion counters.
//
// state  | meaning
// IDLE   | waiting; request enables sampled here only
// ACCESS | stepping halfword slots, SLOT_CYCLES cycles each
// DONE   | one-cycle ready pulse, then back to IDLE
module sram_controller #(
    parameter int unsigned SLOT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_controller_if.slave      bus,
    inout  wire  [15:0]           SRAM_DQ,
    output logic [17:0]           SRAM_ADDR,
    output logic                  SRAM_WE_N,
    output logic                  SRAM_UB_N,
    output logic                  SRAM_LB_N,
    output logic                  SRAM_CE_N,
    output logic                  SRAM_OE_N
`ifdef SRAM_PERF_CNT_EN
    ,
    output logic [15:0]           read_count,
    output logic [15:0]           write_count
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST_C = 4'(SLOT_CYCLES - 1);

    state_t      state_q;
    logic        op_write_q;
    logic [1:0]  slot_q;
    logic [3:0]  cyc_q;
    logic [17:0] base_q;
    logic [31:0] wdata_q;
    logic [63:0] rdata_q;
    logic        ready_q;
    logic [17:0] addr_q;
    logic        we_n_q;
    logic        dq_oe_q;
    logic [15:0] dq_out_q;

    logic [31:0] real_addr;
    logic [17:0] rd_base;
    logic [17:0] wr_base;
    logic        last_slot;
    logic [1:0]  slot_nx;
    logic [3:0]  cyc_nx;

    // Address arithmetic wraps modulo 2^32 for requests below BASE_ADDR.
    assign real_addr = bus.address - BASE_ADDR;
    assign rd_base   = {real_addr[18:3], 2'b00};
    assign wr_base   = {real_addr[18:2], 1'b0};
    assign last_slot = op_write_q ? (slot_q == 2'd1) : (slot_q == 2'd3);
    assign slot_nx   = slot_q + 2'd1;
    assign cyc_nx    = cyc_q + 4'd1;

    assign SRAM_DQ       = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_ADDR     = addr_q;
    assign SRAM_WE_N     = we_n_q;
    assign SRAM_UB_N     = 1'b0;
    assign SRAM_LB_N     = 1'b0;
    assign SRAM_CE_N     = 1'b0;
    assign SRAM_OE_N     = 1'b0;
    assign bus.read_data = rdata_q;
    assign bus.ready     = ready_q;

`ifdef SRAM_PERF_CNT_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;
    assign read_count  = rd_cnt_q;
    assign write_count = wr_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_write_q <= 1'b0;
            slot_q     <= 2'd0;
            cyc_q      <= 4'd0;
            base_q     <= 18'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 64'd0;
            ready_q    <= 1'b0;
            addr_q     <= 18'd0;
            we_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
            dq_out_q   <= 16'd0;
`ifdef SRAM_PERF_CNT_EN
            rd_cnt_q   <= 16'd0;
            wr_cnt_q   <= 16'd0;
`endif
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.read_en) begin
                        state_q    <= ACCESS;
                        op_write_q <= 1'b0;
                        base_q     <= rd_base;
                        addr_q     <= rd_base;
                        slot_q     <= 2'd0;
                        cyc_q      <= 4'd0;
                        we_n_q     <= 1'b1;
                        dq_oe_q    <= 1'b0;
                    end else if (bus.write_en) begin
                        state_q    <= ACCESS;
                        op_write_q <= 1'b1;
                        base_q     <= wr_base;
                        addr_q     <= wr_base;
                        wdata_q    <= bus.write_data;
                        dq_out_q   <= bus.write_data[15:0];
                        slot_q     <= 2'd0;
                        cyc_q      <= 4'd0;
                        we_n_q     <= 1'b0;
                        dq_oe_q    <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cyc_q == LAST_C) begin
                        if (!op_write_q) begin
                            rdata_q[{slot_q, 4'b0000} +: 16] <= SRAM_DQ;
                        end
                        cyc_q <= 4'd0;
                        if (last_slot) begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                            slot_q  <= 2'd0;
                            we_n_q  <= 1'b1;
                            dq_oe_q <= 1'b0;
                        end else begin
                            slot_q   <= slot_nx;
                            addr_q   <= base_q + {16'd0, slot_nx};
                            dq_out_q <= wdata_q[31:16];
                            we_n_q   <= ~op_write_q;
                        end
                    end else begin
                        cyc_q <= cyc_nx;
                        // Release WE one cycle before the slot ends so address/data outlive the strobe.
                        if (cyc_nx == LAST_C) begin
                            we_n_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
`ifdef SRAM_PERF_CNT_EN
                    if (op_write_q) begin
                        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
                    end else begin
                        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
